// File: rtl/tree_node_sched.sv
// Round-robin burst scheduler for one upward merge point of the tree NoC.
// Arbitrates FWFT input buffers onto one registered {valid, payload} output word.
module tree_node_sched #(
    parameter int unsigned n_ports    = 4,
    parameter int unsigned word_width = 16,
    parameter int unsigned burst_max  = 4,
    parameter int unsigned stall_w    = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [n_ports-1:0]                  req,
    input  logic [n_ports*(word_width-1)-1:0]   data_in,
    input  logic                                busy,
    input  logic                                stall_clr,
    output logic [n_ports-1:0]                  rd,
    output logic [word_width-1:0]               out,
    output logic [$clog2(n_ports)-1:0]          grant_idx,
    output logic [stall_w-1:0]                  stall_cycles
);

    localparam int unsigned PW   = word_width - 1;
    localparam int unsigned IdxW = $clog2(n_ports);
    localparam int unsigned CntW = (burst_max > 1) ? $clog2(burst_max) : 1;

    typedef enum logic [1:0] {StIdle, StSend, StStall} state_e;

    state_e                state_q, state_d;
    logic [word_width-1:0] out_q, out_d;
    logic [IdxW-1:0]       grant_q, grant_d;
    logic [IdxW-1:0]       last_q, last_d;
    logic [IdxW-1:0]       win_idx;
    logic [CntW-1:0]       burst_q, burst_d;
    logic                  last_vld_q, last_vld_d;
    logic [stall_w-1:0]    stall_q, stall_d;
    logic                  out_valid, load, found, keep_last;

    assign out_valid = out_q[word_width-1];
    assign load      = ~out_valid | ~busy;

    // last_vld_q blocks burst continuation until a real grant exists, so that
    // after reset port 0 wins first rather than the reset value of last.
    always_comb begin : win_search
        int j;
        j         = 0;
        keep_last = last_vld_q && req[last_q] && (int'(burst_q) < int'(burst_max) - 1);
        found     = 1'b0;
        win_idx   = last_q;
        if (keep_last) begin
            found = 1'b1;
        end else begin
            for (int k = 1; k <= int'(n_ports); k++) begin
                j = int'(last_q) + k;
                if (j >= int'(n_ports)) begin
                    j = j - int'(n_ports);
                end
                if (!found && req[j]) begin
                    found   = 1'b1;
                    win_idx = IdxW'(j);
                end
            end
        end
    end

    always_comb begin
        rd = '0;
        if (!rst && load && found) begin
            rd[win_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        out_d      = out_q;
        grant_d    = grant_q;
        last_d     = last_q;
        last_vld_d = last_vld_q;
        burst_d    = burst_q;
        stall_d    = stall_q;

        if (load) begin
            if (found) begin
                out_d      = {1'b1, data_in[int'(win_idx)*int'(PW) +: PW]};
                grant_d    = win_idx;
                last_d     = win_idx;
                last_vld_d = 1'b1;
                burst_d    = keep_last ? burst_q + CntW'(1) : '0;
                state_d    = StSend;
            end else begin
                out_d[word_width-1] = 1'b0;
                state_d             = StIdle;
            end
        end else begin
            state_d = StStall;
        end

        if (stall_clr) begin
            stall_d = '0;
        end else if (out_valid && busy && (stall_q != '1)) begin
            stall_d = stall_q + stall_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            out_q      <= '0;
            grant_q    <= '0;
            last_q     <= IdxW'(n_ports - 1);
            last_vld_q <= 1'b0;
            burst_q    <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            last_vld_q <= last_vld_d;
            burst_q    <= burst_d;
            stall_q    <= stall_d;
        end
    end

    assign out          = out_q;
    assign grant_idx    = grant_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_tree_node_sched.sv
// Directed, table-driven bench for tree_node_sched (burst_max=4 and a burst_max=1 twin).
module tb_tree_node_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [59:0] data_in;
    logic        busy;
    logic        stall_clr;
    logic [3:0]  rd, rd_rr;
    logic [15:0] dout, dout_rr;
    logic [1:0]  gnt, gnt_rr;
    logic [15:0] stall, stall_rr;

    tree_node_sched #(.n_ports(4), .word_width(16), .burst_max(4), .stall_w(16)) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in), .busy(busy),
        .stall_clr(stall_clr), .rd(rd), .out(dout), .grant_idx(gnt), .stall_cycles(stall)
    );

    tree_node_sched #(.n_ports(4), .word_width(16), .burst_max(1), .stall_w(16)) dut_rr (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in), .busy(busy),
        .stall_clr(stall_clr), .rd(rd_rr), .out(dout_rr), .grant_idx(gnt_rr),
        .stall_cycles(stall_rr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        busy;
        logic        clr;
        logic [3:0]  rd;
        logic [15:0] out;
        logic [1:0]  gnt;
        logic [15:0] stall;
    } vec_t;

    vec_t vecs[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic vec_t mk(logic r, logic [3:0] q, logic b, logic c, logic [3:0] e_rd,
                                logic [15:0] e_out, logic [1:0] e_gnt, logic [15:0] e_st);
        vec_t v;
        v.rst = r; v.req = q; v.busy = b; v.clr = c;
        v.rd = e_rd; v.out = e_out; v.gnt = e_gnt; v.stall = e_st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [3:0] q, input logic b, input logic c);
        rst = r; req = q; busy = b; stall_clr = c;
    endtask

    initial begin
        // Port heads: 0 -> 0x0AB, 1 -> 0x111, 2 -> 0x222, 3 -> 0x123
        data_in = {15'h123, 15'h222, 15'h111, 15'h0AB};
        drive(1'b1, 4'h0, 1'b0, 1'b0);
        tick();
        tick();

        // Reset state; rd must stay low under reset even with requests.
        drive(1'b1, 4'hF, 1'b0, 1'b0);
        #1;
        chk("reset_rd", 32'(rd), 32'h0);
        chk("reset_out", 32'(dout), 32'h0);
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_stall", 32'(stall), 32'h0);
        tick();

        // Single requester, no gaps
        vecs.push_back(mk(0, 4'h1, 0, 0, 4'h1, 16'h0000, 0, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 4'h1, 0, 0, 4'h1, 16'h80AB, 0, 0));
        // All requesting: bursts of four
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 4'hF, 0, 0, 4'h1, 16'h80AB, 0, 0));
        vecs.push_back(mk(0, 4'hF, 0, 0, 4'h2, 16'h80AB, 0, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 4'hF, 0, 0, 4'h2, 16'h8111, 1, 0));
        vecs.push_back(mk(0, 4'hF, 0, 0, 4'h4, 16'h8111, 1, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 4'hF, 0, 0, 4'h4, 16'h8222, 2, 0));
        vecs.push_back(mk(0, 4'hF, 0, 0, 4'h8, 16'h8222, 2, 0));
        for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 4'hF, 0, 0, 4'h8, 16'h8123, 3, 0));
        // busy for 5 cycles holding 0x8123, then release
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 4'hF, 1, 0, 4'h0, 16'h8123, 3, 16'(i)));
        vecs.push_back(mk(0, 4'hF, 0, 0, 4'h1, 16'h8123, 3, 5));
        vecs.push_back(mk(0, 4'hF, 0, 0, 4'h1, 16'h80AB, 0, 5));
        vecs.push_back(mk(0, 4'hF, 0, 1, 4'h1, 16'h80AB, 0, 5));
        vecs.push_back(mk(0, 4'h0, 0, 0, 4'h0, 16'h80AB, 0, 0));
        // Port 2 alone, drops after two words, returns
        vecs.push_back(mk(0, 4'h4, 0, 0, 4'h4, 16'h00AB, 0, 0));
        vecs.push_back(mk(0, 4'h4, 0, 0, 4'h4, 16'h8222, 2, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 4'h0, 16'h8222, 2, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 4'h0, 16'h0222, 2, 0));
        vecs.push_back(mk(0, 4'h4, 0, 0, 4'h4, 16'h0222, 2, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 4'h0, 16'h8222, 2, 0));
        vecs.push_back(mk(0, 4'h0, 0, 0, 4'h0, 16'h0222, 2, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].busy, vecs[i].clr);
            #1;
            chk($sformatf("row%0d_rd", i), 32'(rd), 32'(vecs[i].rd));
            chk($sformatf("row%0d_out", i), 32'(dout), 32'(vecs[i].out));
            chk($sformatf("row%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            chk($sformatf("row%0d_stall", i), 32'(stall), 32'(vecs[i].stall));
            tick();
        end

        // Reset in the middle of a stall with stall_cycles=7
        drive(1'b0, 4'hF, 1'b0, 1'b0);
        #1;
        chk("pre_stall_rd", 32'(rd), 32'h4);
        tick();
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 4'hF, 1'b1, 1'b0);
            #1;
            chk($sformatf("stall_hold%0d_rd", i), 32'(rd), 32'h0);
            tick();
        end
        drive(1'b1, 4'hF, 1'b1, 1'b0);
        #1;
        chk("stall7_count", 32'(stall), 32'd7);
        chk("stall7_out", 32'(dout), 32'h8222);
        chk("rst_cycle_rd", 32'(rd), 32'h0);
        tick();
        drive(1'b0, 4'hF, 1'b0, 1'b0);
        #1;
        chk("post_rst_out", 32'(dout), 32'h0);
        chk("post_rst_stall", 32'(stall), 32'h0);
        chk("post_rst_rd", 32'(rd), 32'h1);
        tick();
        chk("post_rst_first_word", 32'(dout), 32'h80AB);

        // burst_max=1 alternates 1,3; burst_max=4 keeps port 1
        drive(1'b1, 4'h0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'hA, 1'b0, 1'b0);
            #1;
            chk($sformatf("rr%0d_rd", i), 32'(rd_rr), (i % 2 == 0) ? 32'h2 : 32'h8);
            chk($sformatf("b4_%0d_rd", i), 32'(rd), 32'h2);
            tick();
        end
        chk("rr_last_out", 32'(dout_rr), 32'h8123);
        chk("rr_last_gnt", 32'(gnt_rr), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
